uart_tx_engine: RTL
===================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter CLK_HZ, default 50000000, SHALL be the input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, SHALL be the line bit rate; DIV = CLK_HZ/BAUD, truncated; legal DIV >= 4 (default 434).
REQ-003 Parameter FIFO_DEPTH, default 16, SHALL be the byte buffer depth; legal values are powers of two >= 2.
REQ-004 The interface SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-005 CLOCK_50  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 in  input  8  SHALL be the byte to transmit, sampled when send_flag=1.
REQ-008 send_flag  input  1  SHALL push `in` into the FIFO; each clock cycle with send_flag high pushes one byte.
REQ-009 UART_TX  output  1  SHALL be the serial line, registered, idle high.
REQ-010 busy  output  1  SHALL be high while a frame is on the line or the FIFO is non-empty.
REQ-011 fifo_full  output  1  SHALL be high when the FIFO holds FIFO_DEPTH bytes.
REQ-012 overflow  output  1  SHALL be a sticky flag, set by a push that is dropped.
REQ-013 tx_done  output  1  SHALL be a one-cycle pulse in the last cycle of each stop bit.

Function
REQ-014 Framing SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-031), and 1 stop bit (1).
REQ-015 Each bit SHALL occupy exactly DIV clock cycles, timed by a counter that reloads at each bit boundary.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is present only with the macro.
REQ-017 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte into the shift register and enter START on the same edge.
REQ-018 Latency: when idle and the FIFO is empty, UART_TX SHALL fall on the second rising edge after the edge that samples send_flag.
REQ-019 Transitions: START->DATA after DIV cycles; DATA->PARITY/STOP after 8 bits; PARITY->STOP after DIV cycles.
REQ-020 STOP exit: if the FIFO is non-empty, the FSM SHALL pop and go directly to START with no idle bit; otherwise it SHALL go to IDLE.
REQ-021 A push while fifo_full=1 SHALL be dropped and set overflow; FIFO contents SHALL be unchanged.
REQ-022 A push and a pop in the same cycle while full SHALL both succeed, leaving the count unchanged and setting no overflow.
REQ-023 A push and a pop in the same cycle while empty SHALL NOT occur; the pop requires the registered count to be > 0.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; the count width SHALL be clog2(FIFO_DEPTH)+1.
REQ-025 Changes to `in` while send_flag=0, or during a frame, SHALL NOT affect the frame in flight.

Reset
REQ-026 On reset assertion, the following SHALL take effect asynchronously: UART_TX=1, busy=0, fifo_full=0, overflow=0, tx_done=0, state=IDLE, FIFO count and pointers=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately and discard all buffered bytes.
REQ-028 overflow SHALL be cleared only by reset.
REQ-029 After reset deasserts, the first push SHALL behave per REQ-018.
REQ-030 FIFO storage RAM SHALL NOT require reset.

Configuration
REQ-031 With macro UART_TX_PARITY_EN defined, an even parity bit (XOR of the 8 data bits) SHALL be sent between the last data bit and the stop bit; the frame is 11 bits.
REQ-032 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; the frame is 10 bits.

Structure
REQ-033 Shared package uart_pkg SHALL hold the FSM state encoding, the DIV computation function, and the START_BIT, STOP_BIT and DATA_BITS=8 constants.
REQ-034 The FIFO SHALL be the sub-module uart_tx_fifo (parameter DEPTH; ports push, pop, din, dout, count, full); the FSM, baud counter and shift register SHALL stay in the top level.

Verification (CLK_HZ=50000000, BAUD=5000000, DIV=10, FIFO_DEPTH=4)
REQ-035 Push 0xA5 once -> UART_TX low 2 edges later, then bits 1,0,1,0,0,1,0,1, then stop 1, each 10 cycles; tx_done pulses once; busy then drops.
REQ-036 Push 0x00 and 0xFF on consecutive cycles -> two frames back-to-back with no idle gap; the second start bit follows the first stop bit immediately.
REQ-037 Push 6 bytes in 6 consecutive cycles while idle -> the first is popped, 4 are buffered, 1 is dropped, overflow=1, and exactly 5 frames are sent.
REQ-038 Assert reset 35 cycles into the frame for 0x3C with 2 bytes queued -> UART_TX=1 immediately, busy=0, and no further frames are sent.
REQ-039 With UART_TX_PARITY_EN, push 0x07 -> parity bit 1 and a 110-cycle frame; push 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit engine: FSM state encoding,
// framing constants and the baud divider computation.
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity state).
package uart_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } tx_state_t;
`endif

    // Clock cycles per bit, truncated.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmit FSM. First-word fall-through read port:
// dout always shows the oldest byte while count is non-zero.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push while full only lands when a pop frees a slot on the same edge.
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Storage array, no reset needed.
    always_ff @(posedge CLOCK_50) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: byte FIFO, baud counter, shift register and framing FSM.
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1).
// Optional feature macro: UART_TX_PARITY_EN.
import uart_pkg::*;

module uart_tx_engine #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       send_flag,
    output logic       UART_TX,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow,
    output logic       tx_done,
    output tx_state_t  fsm_state
);

    localparam int            DIV      = calc_div(CLK_HZ, BAUD);
    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam int            FAW      = $clog2(FIFO_DEPTH);

    // Handshake: send_flag is a valid with no ready. Every cycle it is high
    // pushes one byte; when fifo_full is high and the FSM does not pop on
    // that same edge, the byte is dropped and overflow latches.

    tx_state_t     state;
    tx_state_t     state_n;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic          bit_end;
    logic          fifo_pop;
    logic          load;
    logic          line_n;
    logic          drop;
    logic [7:0]    fifo_dout;
    logic [FAW:0]  fifo_count;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .push     (send_flag),
        .pop      (fifo_pop),
        .din      (in),
        .dout     (fifo_dout),
        .count    (fifo_count),
        .full     (fifo_full)
    );

    assign bit_end   = (baud_cnt == '0);
    assign drop      = send_flag && fifo_full && !fifo_pop;
    assign fsm_state = state;
    // tx_done covers the final stop-bit cycle still on the line after the FSM returns to IDLE.
    assign busy      = (state != ST_IDLE) || (fifo_count != '0) || tx_done;

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next state, FIFO pop and the line level for the current bit.
    always_comb begin
        state_n  = state;
        fifo_pop = 1'b0;
        load     = 1'b0;
        line_n   = STOP_BIT;
        case (state)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                    state_n  = ST_START;
                end
            end
            ST_START: begin
                line_n = START_BIT;
                if (bit_end) state_n = ST_DATA;
            end
            ST_DATA: begin
                line_n = shift_q[0];
                if (bit_end && bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_n = ST_PARITY;
`else
                    state_n = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                line_n = par_q;
                if (bit_end) state_n = ST_STOP;
            end
`endif
            ST_STOP: begin
                line_n = STOP_BIT;
                if (bit_end) begin
                    // Chain straight into the next start bit when a byte is waiting.
                    if (fifo_count != '0) begin
                        fifo_pop = 1'b1;
                        load     = 1'b1;
                        state_n  = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Baud counter, shift register, registered line and status flags.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            UART_TX  <= STOP_BIT;
            tx_done  <= 1'b0;
            overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            UART_TX <= line_n;
            tx_done <= (state == ST_STOP) && bit_end;
            if (drop) overflow <= 1'b1;
            if (load) begin
                baud_cnt <= DIV_M1;
                bit_idx  <= '0;
                shift_q  <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                par_q    <= ^fifo_dout;
`endif
            end else if (state != ST_IDLE) begin
                if (bit_end) begin
                    baud_cnt <= DIV_M1;
                    if (state == ST_DATA) begin
                        shift_q <= shift_q >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt - CW'(1);
                end
            end
        end
    end

endmodule
